mem_port_arbiter: RTL and testbench

- Shares the single unified instruction/data memory port between the multicycle core's memory interface and the debug/program-loader port.
- Sits between the core datapath's address mux output and the memory macro.
- Arbitrates per transaction, latches the winner's command, sequences the fixed-latency memory access, and returns a one-cycle ready pulse with read data to the winner.

---
 rtl/mem_port_arbiter.sv | 147 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// ----------------
// The core's memory interface and the debug/program-loader port share one
// unified memory port. This block arbitrates per transaction and latches the
// winner's command. It then runs the fixed-latency memory access and returns a
// one-cycle ready pulse, with read data, to the winner.
//
// Arbitration on a tie:
//   default build            : round-robin, starting with the core after reset
//   MEM_ARB_FIXED_PRIO_EN    : the core always wins a tie
//
// Ports
//   clk, reset                     clock (rising edge), async active-low reset
//   core_req/we/addr/wdata         core command, req held until core_rdy
//   core_rdy, core_rdata           completion pulse and read data to core
//   dbg_req/we/addr/wdata          debug command, req held until dbg_rdy
//   dbg_rdy, dbg_rdata             completion pulse and read data to debug
//   mem_en/we/addr/wdata           memory command (mem_en one cycle per access)
//   mem_rdata                      memory read data, valid RD_LAT after mem_en
//   busy                           any state other than IDLE
//   gnt_dbg                        current transaction belongs to debug
module mem_port_arbiter #(
    parameter int AW     = 32,
    parameter int DW     = 32,
    parameter int RD_LAT = 1     // 1..4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          core_req,
    input  logic          core_we,
    input  logic [AW-1:0] core_addr,
    input  logic [DW-1:0] core_wdata,
    output logic          core_rdy,
    output logic [DW-1:0] core_rdata,
    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    output logic          dbg_rdy,
    output logic [DW-1:0] dbg_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy,
    output logic          gnt_dbg
);

    localparam int CW = 2;   // wide enough for RD_LAT-1 up to 3

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t          state_reg, state_next;
    logic            gnt_dbg_reg;
    logic            mem_we_reg;
    logic [AW-1:0]   mem_addr_reg;
    logic [DW-1:0]   mem_wdata_reg;
    logic [CW-1:0]   cnt_reg;
    logic [DW-1:0]   core_rdata_reg;
    logic [DW-1:0]   dbg_rdata_reg;
    logic            pick_dbg;

`ifdef MEM_ARB_FIXED_PRIO_EN
    // Debug only gets the port when the core is not asking for it.
    assign pick_dbg = dbg_req && !core_req;
`else
    // last_gnt_reg = 1 means debug won the previous transaction. A tie goes to
    // the requester that did not win last time.
    logic last_gnt_reg;

    assign pick_dbg = dbg_req && (!core_req || !last_gnt_reg);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_gnt_reg <= 1'b1;            // core wins the first tie
        end else if (state_reg == ISSUE) begin
            last_gnt_reg <= gnt_dbg_reg;
        end
    end
`endif

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (core_req || dbg_req) state_next = ISSUE;
            ISSUE:   state_next = mem_we_reg ? RESP : WAIT;
            WAIT:    if (cnt_reg == '0) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg      <= IDLE;
            gnt_dbg_reg    <= 1'b0;
            mem_we_reg     <= 1'b0;
            mem_addr_reg   <= '0;
            mem_wdata_reg  <= '0;
            cnt_reg        <= '0;
            core_rdata_reg <= '0;
            dbg_rdata_reg  <= '0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    // The command register doubles as the memory command
                    // outputs. It keeps its value between transactions.
                    if (core_req || dbg_req) begin
                        gnt_dbg_reg   <= pick_dbg;
                        mem_we_reg    <= pick_dbg ? dbg_we    : core_we;
                        mem_addr_reg  <= pick_dbg ? dbg_addr  : core_addr;
                        mem_wdata_reg <= pick_dbg ? dbg_wdata : core_wdata;
                    end
                end
                ISSUE: begin
                    cnt_reg <= CW'(RD_LAT - 1);
                end
                WAIT: begin
                    cnt_reg <= cnt_reg - CW'(1);
                    // Count 0 marks the cycle in which mem_rdata is valid.
                    if (cnt_reg == '0) begin
                        if (gnt_dbg_reg) dbg_rdata_reg  <= mem_rdata;
                        else             core_rdata_reg <= mem_rdata;
                    end
                end
                RESP: begin
                    gnt_dbg_reg <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign mem_en     = (state_reg == ISSUE);
    assign mem_we     = mem_we_reg;
    assign mem_addr   = mem_addr_reg;
    assign mem_wdata  = mem_wdata_reg;
    assign busy       = (state_reg != IDLE);
    assign gnt_dbg    = gnt_dbg_reg;
    assign core_rdy   = (state_reg == RESP) && !gnt_dbg_reg;
    assign dbg_rdy    = (state_reg == RESP) &&  gnt_dbg_reg;
    assign core_rdata = core_rdata_reg;
    assign dbg_rdata  = dbg_rdata_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter, built with RD_LAT = 2. A small
// memory model with two-cycle read latency sits on the memory port. Outputs are
// checked 1 time unit after each rising edge.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        core_req, core_we, core_rdy;
    logic [31:0] core_addr, core_wdata, core_rdata;
    logic        dbg_req, dbg_we, dbg_rdy;
    logic [31:0] dbg_addr, dbg_wdata, dbg_rdata;
    logic        mem_en, mem_we, busy, gnt_dbg;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int errors = 0;
    int checks = 0;
    int mem_en_count = 0;
    int en_before;
    logic [3:0] exp_gnt;

    always #5 clk = ~clk;

    mem_port_arbiter #(.AW(32), .DW(32), .RD_LAT(2)) dut (
        .clk(clk), .reset(reset),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_rdy(core_rdy), .core_rdata(core_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
        .dbg_wdata(dbg_wdata), .dbg_rdy(dbg_rdy), .dbg_rdata(dbg_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy), .gnt_dbg(gnt_dbg)
    );

    // Memory model: 16 words, read data appears two cycles after mem_en.
    logic [31:0] mem_arr [0:15];
    logic [31:0] rd_p1, rd_p2;
    always @(posedge clk) begin
        if (mem_en && mem_we) mem_arr[mem_addr[5:2]] <= mem_wdata;
        rd_p1 <= mem_arr[mem_addr[5:2]];
        rd_p2 <= rd_p1;
        if (mem_en) mem_en_count <= mem_en_count + 1;
    end
    assign mem_rdata = rd_p2;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        core_req = 0; core_we = 0; core_addr = '0; core_wdata = '0;
        dbg_req = 0;  dbg_we = 0;  dbg_addr = '0;  dbg_wdata = '0;
`ifdef MEM_ARB_FIXED_PRIO_EN
        exp_gnt = 4'b0000;
`else
        exp_gnt = 4'b1010;   // bit i = 1: grant i goes to debug
`endif
        #1;
        // ---- reset state
        chk("rst_busy", busy, 0);
        chk("rst_gnt_dbg", gnt_dbg, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_core_rdy", core_rdy, 0);
        chk("rst_dbg_rdy", dbg_rdy, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_core_rdata", core_rdata, 0);
        tick(); tick();
        reset = 1'b1;
        tick();
        $display("txn reset: done");

        // ---- core write 0x10 = DEADBEEF (cycle N = this cycle)
        core_req = 1; core_we = 1; core_addr = 32'h10; core_wdata = 32'hDEAD_BEEF;
        tick();  // N+1
        chk("cw_mem_en", mem_en, 1);
        chk("cw_mem_we", mem_we, 1);
        chk("cw_mem_addr", mem_addr, 32'h10);
        chk("cw_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        chk("cw_gnt_dbg", gnt_dbg, 0);
        core_req = 0;                    // dropping req does not abort
        tick();  // N+2
        chk("cw_core_rdy", core_rdy, 1);
        chk("cw_dbg_rdy", dbg_rdy, 0);
        chk("cw_mem_en_off", mem_en, 0);
        tick();  // N+3
        chk("cw_core_rdy_off", core_rdy, 0);
        chk("cw_busy_off", busy, 0);
        $display("txn core write addr=10 data=deadbeef");

        // ---- debug read 0x10 (cycle M = this cycle)
        dbg_req = 1; dbg_we = 0; dbg_addr = 32'h10;
        tick();  // M+1
        chk("dr_gnt_dbg1", gnt_dbg, 1);
        chk("dr_mem_en", mem_en, 1);
        chk("dr_mem_we", mem_we, 0);
        chk("dr_mem_addr", mem_addr, 32'h10);
        dbg_req = 0;
        tick();  // M+2
        chk("dr_gnt_dbg2", gnt_dbg, 1);
        chk("dr_rdy_early2", dbg_rdy, 0);
        tick();  // M+3
        chk("dr_rdy_early3", dbg_rdy, 0);
        tick();  // M+4
        chk("dr_dbg_rdy", dbg_rdy, 1);
        chk("dr_core_rdy", core_rdy, 0);
        chk("dr_dbg_rdata", dbg_rdata, 32'hDEAD_BEEF);
        chk("dr_gnt_dbg4", gnt_dbg, 1);
        tick();  // M+5
        chk("dr_gnt_dbg_off", gnt_dbg, 0);
        chk("dr_rdy_off", dbg_rdy, 0);
        $display("txn debug read addr=10 data=%h", dbg_rdata);

        // ---- contention straight after reset
        reset = 1'b0;
        tick();
        reset = 1'b1;
        en_before = mem_en_count;
        core_req = 1; core_we = 1; core_addr = 32'h20; core_wdata = 32'hC0C0_C0C0;
        dbg_req  = 1; dbg_we  = 1; dbg_addr  = 32'h24; dbg_wdata  = 32'hD0D0_D0D0;
        for (int i = 0; i < 4; i++) begin
            tick();  // ISSUE
            chk($sformatf("ct%0d_gnt_dbg", i), gnt_dbg, exp_gnt[i]);
            chk($sformatf("ct%0d_mem_addr", i), mem_addr, exp_gnt[i] ? 32'h24 : 32'h20);
            tick();  // RESP
            chk($sformatf("ct%0d_core_rdy", i), core_rdy, !exp_gnt[i]);
            chk($sformatf("ct%0d_dbg_rdy", i), dbg_rdy, exp_gnt[i]);
            tick();  // IDLE, both still requesting
            $display("txn contention grant %0d to %s", i, exp_gnt[i] ? "debug" : "core");
        end
        core_req = 0;                    // only debug left
        tick();  // ISSUE
        chk("ct4_gnt_dbg", gnt_dbg, 1);
        chk("ct4_mem_addr", mem_addr, 32'h24);
        tick();  // RESP
        chk("ct4_dbg_rdy", dbg_rdy, 1);
        dbg_req = 0;
        tick();  // IDLE
        chk("ct_mem_en_count", 32'(mem_en_count - en_before), 5);
        $display("txn contention grant 4 to debug");

        // ---- reset during WAIT of a core read
        core_req = 1; core_we = 0; core_addr = 32'h20;
        tick();  // ISSUE
        chk("rw_mem_en", mem_en, 1);
        tick();  // WAIT
        chk("rw_busy", busy, 1);
        reset = 1'b0;
        #1;
        chk("rw_rst_busy", busy, 0);
        chk("rw_rst_mem_en", mem_en, 0);
        chk("rw_rst_mem_addr", mem_addr, 0);
        chk("rw_rst_mem_we", mem_we, 0);
        chk("rw_rst_gnt_dbg", gnt_dbg, 0);
        chk("rw_rst_core_rdy", core_rdy, 0);
        core_req = 0;
        tick();
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("rw_no_rdy%0d", i), core_rdy, 0);
        end
        $display("txn reset during core read wait: aborted");
        core_req = 1; core_we = 0; core_addr = 32'h20;
        tick();  // ISSUE
        chk("rn_mem_addr", mem_addr, 32'h20);
        core_req = 0;
        tick(); tick();  // WAIT x2
        chk("rn_rdy_early", core_rdy, 0);
        tick();  // RESP
        chk("rn_core_rdy", core_rdy, 1);
        chk("rn_core_rdata", core_rdata, 32'hC0C0_C0C0);
        tick();
        $display("txn core read addr=20 data=%h", core_rdata);

        // ---- address change after grant is not seen by the current access
        core_req = 1; core_we = 1; core_addr = 32'h20; core_wdata = 32'h1234_5678;
        tick();  // ISSUE
        core_addr = 32'h40; core_wdata = 32'h9ABC_DEF0;
        #1;
        chk("ac_mem_addr1", mem_addr, 32'h20);
        chk("ac_mem_wdata1", mem_wdata, 32'h1234_5678);
        tick();  // RESP
        chk("ac_core_rdy1", core_rdy, 1);
        chk("ac_mem_en_resp", mem_en, 0);
        tick();  // IDLE, req re-sampled
        chk("ac_busy_idle", busy, 0);
        chk("ac_mem_addr_hold", mem_addr, 32'h20);
        tick();  // ISSUE of second transaction
        chk("ac_mem_en2", mem_en, 1);
        chk("ac_mem_addr2", mem_addr, 32'h40);
        chk("ac_mem_wdata2", mem_wdata, 32'h9ABC_DEF0);
        core_req = 0;
        tick();  // RESP
        chk("ac_core_rdy2", core_rdy, 1);
        tick();
        chk("ac_rdata_hold", core_rdata, 32'hC0C0_C0C0);
        chk("ac_mem_addr_hold2", mem_addr, 32'h40);
        $display("txn core write addr=20 then addr=40");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
